// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video flag, sync pulses
// and line/frame start strobes, with a configurable output delay line.
// Optional feature macro: VTG_FRAME_COUNT_EN adds a 16-bit completed-frame counter.
module video_timing_gen #(
  parameter int unsigned CW           = 11,
  parameter int unsigned H_ACTIVE     = 1280,
  parameter int unsigned H_SYNC_START = 1390,
  parameter int unsigned H_SYNC_END   = 1430,
  parameter int unsigned H_TOTAL      = 1650,
  parameter int unsigned V_ACTIVE     = 720,
  parameter int unsigned V_SYNC_START = 725,
  parameter int unsigned V_SYNC_END   = 730,
  parameter int unsigned V_TOTAL      = 750,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned PIPE_LAT     = 0
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] CounterX,
  output logic [CW-1:0] CounterY,
  output logic          DrawArea,
  output logic          hSync,
  output logic          vSync,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  // Reject impossible geometries before anything gets built.
  if (!(H_ACTIVE <= H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
    $error("video_timing_gen: horizontal timing must satisfy ACTIVE <= SYNC_START < SYNC_END <= TOTAL");
  end
  if (!(V_ACTIVE <= V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
    $error("video_timing_gen: vertical timing must satisfy ACTIVE <= SYNC_START < SYNC_END <= TOTAL");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("video_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (PIPE_LAT > 15) begin : g_bad_lat
    $error("video_timing_gen: PIPE_LAT must be 0..15");
  end

  localparam int unsigned NSTG = PIPE_LAT + 1;

  // Comparisons are done one bit wider so a boundary equal to 2^CW still works.
  localparam logic [CW:0]   H_ACT_W = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   H_SS_W  = (CW+1)'(H_SYNC_START);
  localparam logic [CW:0]   H_SE_W  = (CW+1)'(H_SYNC_END);
  localparam logic [CW:0]   V_ACT_W = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   V_SS_W  = (CW+1)'(V_SYNC_START);
  localparam logic [CW:0]   V_SE_W  = (CW+1)'(V_SYNC_END);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, ls: 1'b0, fs: 1'b0};

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          x_wrap, y_wrap;
  logic [CW:0]   x_ext, y_ext;
  ctl_t          stage0_new;
  ctl_t          pipe_q [NSTG];
  ctl_t          pipe_d [NSTG];

  // Next counter values; the whole raster freezes while en is low.
  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (en) begin
      x_d = x_wrap ? '0 : x_q + CW'(1);
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + CW'(1);
      end
    end
  end

  // Decode the current counter position into the control word for stage 0.
  always_comb begin
    x_ext         = {1'b0, x_q};
    y_ext         = {1'b0, y_q};
    stage0_new    = CTL_IDLE;
    stage0_new.de = (x_ext < H_ACT_W) && (y_ext < V_ACT_W);
    stage0_new.hs = (x_ext >= H_SS_W && x_ext < H_SE_W) ? HS_POL : ~HS_POL;
    stage0_new.vs = (y_ext >= V_SS_W && y_ext < V_SE_W) ? VS_POL : ~VS_POL;
    stage0_new.ls = (x_q == '0);
    stage0_new.fs = (x_q == '0) && (y_q == '0);
  end

  // Delay line: stage 0 takes the fresh decode, later stages shift; all hold when paused.
  always_comb begin
    pipe_d[0] = en ? stage0_new : pipe_q[0];
    for (int i = 1; i < int'(NSTG); i++) begin
      pipe_d[i] = en ? pipe_q[i-1] : pipe_q[i];
    end
  end

  // Counter and delay-line state; reset puts every stage in its inactive level.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      for (int i = 0; i < int'(NSTG); i++) begin
        pipe_q[i] <= CTL_IDLE;
      end
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      for (int i = 0; i < int'(NSTG); i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Count completed frames at the last pixel of the last line (undelayed).
  always_comb begin
    frame_count_d = frame_count_q;
    if (en && x_wrap && y_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge pixclk) begin
    if (rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign CounterX    = x_q;
  assign CounterY    = y_q;
  assign DrawArea    = pipe_q[NSTG-1].de;
  assign hSync       = pipe_q[NSTG-1].hs;
  assign vSync       = pipe_q[NSTG-1].vs;
  // Strobes must never fire on a frozen pixel, so they are masked by en.
  assign line_start  = pipe_q[NSTG-1].ls & en;
  assign frame_start = pipe_q[NSTG-1].fs & en;

endmodule
